// File: rtl/ring_mon_pkg.sv
// rtl/ring_mon_pkg.sv - shared types and rotation helper for one-hot ring consumers
package ring_mon_pkg;

  typedef enum logic [1:0] {ACQUIRE, LOCKED, FAULT} ring_mon_state_t;

  localparam int unsigned RING_MAX_W = 64;

  // Expected successor of prev in an n-wide ring; dir=0 rotates right, dir=1 rotates left.
  function automatic logic [RING_MAX_W-1:0] rot_next(input logic [RING_MAX_W-1:0] prev,
                                                     input int unsigned n,
                                                     input logic dir);
    logic [RING_MAX_W-1:0] nxt;
    logic [5:0]            src;
    nxt = '0;
    src = '0;
    for (int unsigned i = 0; i < RING_MAX_W; i++) begin
      if (i < n) begin
        if (!dir) src = (i == n - 1) ? 6'd0 : 6'(i + 1);
        else      src = (i == 0) ? 6'(n - 1) : 6'(i - 1);
        nxt[i] = prev[src];
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - combinational one-hot to binary encoder with one-hot validity flag
module onehot_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_oh_ok
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] w_count;

  // OR-ing indices is exact when one bit is set; o_oh_ok qualifies the result.
  always_comb begin
    w_count = '0;
    o_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        w_count = w_count + CNT_W'(1);
        o_idx   = o_idx | IDX_W'(i);
      end
    end
    o_oh_ok = (w_count == CNT_W'(1));
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - decodes a one-hot ring phase, checks rotation, locks and counts revolutions
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = N,
  parameter int REV_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         phase_in,
  input  logic                 phase_valid,
  input  logic                 clear_err,
  output logic [$clog2(N)-1:0] idx,
  output logic                 idx_valid,
  output logic                 locked,
  output logic                 rev_tick,
  output logic [REV_W-1:0]     rev_count,
  output logic                 err_onehot,
  output logic                 err_seq
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  ring_mon_state_t r_state, w_state_n;

  logic [IDX_W-1:0]      r_idx;
  logic                  r_idx_valid;
  logic                  r_locked;
  logic                  r_rev_tick;
  logic [REV_W-1:0]      r_rev_count;
  logic                  r_err_onehot;
  logic                  r_err_seq;
  logic [N-1:0]          r_prev;
  logic                  r_have_prev;
  logic [CNT_W-1:0]      r_good_cnt;

  logic [IDX_W-1:0]      w_idx;
  logic                  w_oh_ok;
  logic                  w_seq_ok;
  logic [RING_MAX_W-1:0] w_rot_full;
  logic [N-1:0]          w_rot;
  logic [CNT_W-1:0]      w_good_n;
  logic [REV_W-1:0]      w_rev_n;
  logic                  w_tick_n;
  logic                  w_err_oh_n;
  logic                  w_err_seq_n;

  onehot_enc #(.N(N)) u_enc (
    .i_vec   (phase_in),
    .o_idx   (w_idx),
    .o_oh_ok (w_oh_ok)
  );

  assign w_rot_full = rot_next(RING_MAX_W'(r_prev), N, DIR != 0);
  assign w_rot      = w_rot_full[N-1:0];
  assign w_seq_ok   = !r_have_prev || (phase_in == w_rot);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ACQUIRE;
    else       r_state <= w_state_n;
  end

  // clear_err outranks the checks; the sample in that cycle only seeds prev.
  always_comb begin
    w_state_n   = r_state;
    w_good_n    = r_good_cnt;
    w_rev_n     = r_rev_count;
    w_tick_n    = 1'b0;
    w_err_oh_n  = r_err_onehot;
    w_err_seq_n = r_err_seq;
    if (clear_err) begin
      w_state_n   = ACQUIRE;
      w_good_n    = '0;
      w_err_oh_n  = 1'b0;
      w_err_seq_n = 1'b0;
    end else if (phase_valid) begin
      case (r_state)
        ACQUIRE: begin
          if (w_oh_ok && r_have_prev && w_seq_ok) begin
            if (r_good_cnt == CNT_W'(LOCK_CNT - 1)) begin
              w_state_n = LOCKED;
              w_good_n  = '0;
            end else begin
              w_good_n = r_good_cnt + CNT_W'(1);
            end
          end else begin
            w_good_n = '0;
          end
        end
        LOCKED: begin
          if (!w_oh_ok) begin
            w_err_oh_n = 1'b1;
            w_state_n  = FAULT;
          end else if (!w_seq_ok) begin
            w_err_seq_n = 1'b1;
            w_state_n   = FAULT;
          end else if (phase_in == N'(1)) begin
            w_tick_n = 1'b1;
            w_rev_n  = r_rev_count + REV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_idx_valid  <= 1'b0;
      r_locked     <= 1'b0;
      r_rev_tick   <= 1'b0;
      r_rev_count  <= '0;
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_prev       <= '0;
      r_have_prev  <= 1'b0;
      r_good_cnt   <= '0;
    end else begin
      r_idx_valid  <= phase_valid && w_oh_ok;
      r_locked     <= (w_state_n == LOCKED);
      r_rev_tick   <= w_tick_n;
      r_rev_count  <= w_rev_n;
      r_err_onehot <= w_err_oh_n;
      r_err_seq    <= w_err_seq_n;
      r_good_cnt   <= w_good_n;
      if (phase_valid) begin
        if (w_oh_ok) begin
          r_idx       <= w_idx;
          r_prev      <= phase_in;
          r_have_prev <= 1'b1;
        end else begin
          r_have_prev <= 1'b0;
        end
      end
    end
  end

  assign idx        = r_idx;
  assign idx_valid  = r_idx_valid;
  assign locked     = r_locked;
  assign rev_tick   = r_rev_tick;
  assign rev_count  = r_rev_count;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb/tb_ring_phase_monitor.sv - table-driven scoreboard bench for ring_phase_monitor
module tb_ring_phase_monitor;

  typedef struct packed {
    logic [1:0] idx;
    logic       iv;
    logic       lk;
    logic       tk;
    logic       eoh;
    logic       esq;
    logic [7:0] rc;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [3:0] ph;
    logic       clr;
    out_t       exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] phase_in;
  logic       phase_valid;
  logic       clear_err;
  logic [1:0] idx;
  logic       idx_valid;
  logic       locked;
  logic       rev_tick;
  logic [7:0] rev_count;
  logic       err_onehot;
  logic       err_seq;

  int   checks;
  int   errors;
  out_t exp_q[$];
  vec_t vecs[$];
  out_t act;

  ring_phase_monitor #(.N(4), .DIR(0), .LOCK_CNT(4), .REV_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .clear_err   (clear_err),
    .idx         (idx),
    .idx_valid   (idx_valid),
    .locked      (locked),
    .rev_tick    (rev_tick),
    .rev_count   (rev_count),
    .err_onehot  (err_onehot),
    .err_seq     (err_seq)
  );

  assign act = {idx, idx_valid, locked, rev_tick, err_onehot, err_seq, rev_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic vld, input logic [3:0] ph, input logic clr,
                             input logic [1:0] ei, input logic eiv, input logic elk, input logic etk,
                             input logic eoh, input logic esq, input logic [7:0] erc);
    vec_t r;
    r.rst = rst; r.vld = vld; r.ph = ph; r.clr = clr;
    r.exp = {ei, eiv, elk, etk, eoh, esq, erc};
    return r;
  endfunction

  task automatic step(input vec_t s, input string name);
    out_t e;
    @(negedge clk);
    reset       = s.rst;
    phase_valid = s.vld;
    phase_in    = s.ph;
    clear_err   = s.clr;
    exp_q.push_back(s.exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got idx=%0d iv=%b lk=%b tick=%b eoh=%b eseq=%b rc=%0d, expected idx=%0d iv=%b lk=%b tick=%b eoh=%b eseq=%b rc=%0d",
               name, act.idx, act.iv, act.lk, act.tk, act.eoh, act.esq, act.rc,
               e.idx, e.iv, e.lk, e.tk, e.eoh, e.esq, e.rc);
    end
  endtask

  initial begin
    int   rc;
    vec_t s;
    checks = 0; errors = 0;
    reset = 1'b1; phase_valid = 1'b0; phase_in = 4'b0000; clear_err = 1'b0;

    // reset, then lock and first revolution
    vecs.push_back(v(1,0,4'b0000,0, 0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,0,0,0,0,0));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,0,0,0,0,0));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,0,0,0,0,0));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,0,0,0));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,0,0,0,0));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,1,0,0,0,0));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,1,0,0,0,0));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,1,0,0,0,0));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,1,0,0,1));
    // decode, then 0000 sample while locked
    vecs.push_back(v(0,1,4'b1000,0, 3,1,1,0,0,0,1));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,1,0,0,0,1));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,1,0,0,2));
    vecs.push_back(v(0,1,4'b0000,0, 0,0,0,0,1,0,2));
    vecs.push_back(v(0,0,4'b0000,1, 0,0,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,0,0,0,2));
    // one-hot fault: flags stick, decode continues, no tick in FAULT
    vecs.push_back(v(0,1,4'b0011,0, 0,0,0,0,1,0,2));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,0,0,1,0,2));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,0,0,1,0,2));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,1,0,2));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,0,0,1,0,2));
    // clear with seed sample, relock
    vecs.push_back(v(0,1,4'b1000,1, 3,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,0,0,0,0,2));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,1,0,0,0,2));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,1,0,0,0,2));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,1,0,0,0,2));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,1,0,0,3));
    // sequence fault: 1000 legal, 0010 skips a phase
    vecs.push_back(v(0,1,4'b1000,0, 3,1,1,0,0,0,3));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,0,1,3));
    vecs.push_back(v(0,1,4'b0001,1, 0,1,0,0,0,0,3));
    vecs.push_back(v(0,1,4'b1000,0, 3,1,0,0,0,0,3));
    vecs.push_back(v(0,1,4'b0100,0, 2,1,0,0,0,0,3));
    vecs.push_back(v(0,1,4'b0010,0, 1,1,0,0,0,0,3));
    vecs.push_back(v(0,1,4'b0001,0, 0,1,1,0,0,0,3));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // stall mid-rotation
    step(v(0,1,4'b1000,0, 3,1,1,0,0,0,3), "stall_pre0");
    step(v(0,1,4'b0100,0, 2,1,1,0,0,0,3), "stall_pre1");
    for (int i = 0; i < 3; i++) step(v(0,0,4'b1111,0, 2,0,1,0,0,0,3), $sformatf("stall%0d", i));
    step(v(0,1,4'b0010,0, 1,1,1,0,0,0,3), "stall_resume");
    step(v(0,1,4'b0001,0, 0,1,1,1,0,0,4), "stall_tick");

    // 256 revolutions: count must wrap back to its start value
    rc = 4;
    for (int r = 0; r < 256; r++) begin
      step(v(0,1,4'b1000,0, 3,1,1,0,0,0,8'(rc)), "wrap_a");
      step(v(0,1,4'b0100,0, 2,1,1,0,0,0,8'(rc)), "wrap_b");
      step(v(0,1,4'b0010,0, 1,1,1,0,0,0,8'(rc)), "wrap_c");
      rc = (rc + 1) % 256;
      step(v(0,1,4'b0001,0, 0,1,1,1,0,0,8'(rc)), $sformatf("wrap_tick%0d", r));
    end

    // reach rev_count=5 with err_seq set, then reset mid-operation
    step(v(0,1,4'b1000,0, 3,1,1,0,0,0,4), "pre_rst0");
    step(v(0,1,4'b0100,0, 2,1,1,0,0,0,4), "pre_rst1");
    step(v(0,1,4'b0010,0, 1,1,1,0,0,0,4), "pre_rst2");
    step(v(0,1,4'b0001,0, 0,1,1,1,0,0,5), "pre_rst3");
    step(v(0,1,4'b0100,0, 2,1,0,0,0,1,5), "pre_rst_seqerr");
    step(v(1,1,4'b0010,0, 0,0,0,0,0,0,0), "reset_mid");
    step(v(0,1,4'b0010,0, 1,1,0,0,0,0,0), "post_rst_seed");
    step(v(0,1,4'b0100,0, 2,1,0,0,0,0,0), "post_rst_noerr");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
